// File: rtl/pgm_pkg.sv
// pgm_pkg
//   Shared types and constants for the PGM graphics-ROM DDR bridge.
//   - gfx_state_e    : bridge controller states
//   - GFX_*          : default geometry (lines, beats per line) and the
//                      derived address-split widths
//   - GFX_BASE_WADDR : DDR word offset of the graphics ROM region
//   - tagWidth()     : tag width left over once offset and index are removed
package pgm_pkg;

  localparam int ADDR_W = 29;
  localparam int DATA_W = 64;

  localparam int GFX_LINES = 16;
  localparam int GFX_BURST = 4;
  localparam int GFX_OFF_W = $clog2(GFX_BURST);
  localparam int GFX_IDX_W = $clog2(GFX_LINES);
  localparam int GFX_TAG_W = ADDR_W - GFX_OFF_W - GFX_IDX_W;

  localparam logic [ADDR_W-1:0] GFX_BASE_WADDR = 29'h0600000;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    ISSUE,
    FILL,
    RESPOND
  } gfx_state_e;

  function automatic int tagWidth(input int lines, input int burst);
    return ADDR_W - $clog2(lines) - $clog2(burst);
  endfunction

endpackage

// File: rtl/pgm_gfx_line_ram.sv
// pgm_gfx_line_ram
//   Simple dual-port 64-bit data store holding the cache lines, written
//   with a plain synchronous write and read through a registered read
//   port so that it maps onto block RAM.
//   Ports:
//     clk      - clock
//     we_i     - write enable
//     waddr_i  - write word address {line index, beat}
//     wdata_i  - write data
//     raddr_i  - read word address {line index, offset}
//     rdata_o  - read data, one cycle after raddr_i
module pgm_gfx_line_ram
  import pgm_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/pgm_gfx_ddr_bridge.sv
// pgm_gfx_ddr_bridge
//   Responder for the PGM video engine's graphics-ROM read port. Single
//   64-bit word reads are served from a direct-mapped line cache; misses
//   refill a whole line with one fixed-length burst on the DDR3 port.
//   Ports:
//     clk, reset        - clock, synchronous active-high reset
//     ddram_rd          - client read request (level, accepted on its rising edge)
//     ddram_addr        - client word address, ROM-relative
//     ddram_busy        - high whenever the bridge is not idle
//     ddram_dout        - read data, valid with ddram_dout_ready
//     ddram_dout_ready  - one-cycle data-valid pulse
//     flush             - invalidate every line
//     mem_rd, mem_addr, mem_burstcnt - DDR burst read command
//     mem_waitrequest   - DDR command stall
//     mem_dout, mem_dout_ready       - DDR returned beats
module pgm_gfx_ddr_bridge
  import pgm_pkg::*;
#(
  parameter int                LINES      = GFX_LINES,
  parameter int                BURST      = GFX_BURST,
  parameter logic [ADDR_W-1:0] BASE_WADDR = GFX_BASE_WADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ddram_rd,
  input  logic [ADDR_W-1:0] ddram_addr,
  output logic              ddram_busy,
  output logic [DATA_W-1:0] ddram_dout,
  output logic              ddram_dout_ready,
  input  logic              flush,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_burstcnt,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_dout_ready
);

  localparam int OFF_W = $clog2(BURST);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = tagWidth(LINES, BURST);

  gfx_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] bypass_q, bypass_d;
  logic              fromFill_q, fromFill_d;
  logic              flushPend_q, flushPend_d;
  logic              rdPrev_q;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q [LINES];

  logic              flushAll;
  logic              lineDone;
  logic              ramWe;
  logic [DATA_W-1:0] ramRdata;

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  assign off = addr_q[OFF_W-1:0];
  assign idx = addr_q[OFF_W +: IDX_W];
  assign tag = addr_q[ADDR_W-1 -: TAG_W];

  assign ddram_busy = (state_q != IDLE);

  pgm_gfx_line_ram #(
    .DEPTH (LINES * BURST),
    .AW    (IDX_W + OFF_W)
  ) u_lineRam (
    .clk     (clk),
    .we_i    (ramWe),
    .waddr_i ({idx, beat_q}),
    .wdata_i (mem_dout),
    .raddr_i ({idx, off}),
    .rdata_o (ramRdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      beat_q      <= '0;
      bypass_q    <= '0;
      fromFill_q  <= 1'b0;
      flushPend_q <= 1'b0;
      rdPrev_q    <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      bypass_q    <= bypass_d;
      fromFill_q  <= fromFill_d;
      flushPend_q <= flushPend_d;
      rdPrev_q    <= ddram_rd;
      if (flushAll) begin
        valid_q <= '0;
      end
      if (lineDone) begin
        valid_q[idx] <= 1'b1;
        tag_q[idx]   <= tag;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    beat_d           = beat_q;
    bypass_d         = bypass_q;
    fromFill_d       = fromFill_q;
    flushPend_d      = flushPend_q;
    flushAll         = 1'b0;
    lineDone         = 1'b0;
    ramWe            = 1'b0;
    ddram_dout       = '0;
    ddram_dout_ready = 1'b0;
    mem_rd           = 1'b0;
    mem_addr         = '0;
    mem_burstcnt     = '0;

    case (state_q)
      IDLE: begin
        if (flush || flushPend_q) begin
          flushAll    = 1'b1;
          flushPend_d = 1'b0;
        end
        // Only a rising edge of the request level starts a transaction.
        if (ddram_rd && !rdPrev_q) begin
          addr_d  = ddram_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        beat_d = '0;
        if (valid_q[idx] && (tag_q[idx] == tag)) begin
          fromFill_d = 1'b0;
          state_d    = RESPOND;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd       = 1'b1;
        mem_addr     = BASE_WADDR + {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        mem_burstcnt = 8'(BURST);
        if (!mem_waitrequest) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (mem_dout_ready) begin
          ramWe  = 1'b1;
          beat_d = beat_q + OFF_W'(1);
          // The requested beat is kept aside: the RAM read port would
          // otherwise race the final write when off is the last beat.
          if (beat_q == off) begin
            bypass_d = mem_dout;
          end
          if (beat_q == OFF_W'(BURST - 1)) begin
            lineDone   = 1'b1;
            fromFill_d = 1'b1;
            state_d    = RESPOND;
          end
        end
      end
      RESPOND: begin
        ddram_dout_ready = 1'b1;
        ddram_dout       = fromFill_q ? bypass_q : ramRdata;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush && (state_q != IDLE)) begin
      flushPend_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_pgm_gfx_ddr_bridge.sv
// tb_pgm_gfx_ddr_bridge
//   Self-checking bench: directed cases for cold miss, hit, eviction,
//   waitrequest stall, held request level, flush and reset mid-fill, then
//   randomized reads compared against a line-level cache model.
module tb_pgm_gfx_ddr_bridge;

  localparam int          LINES = 16;
  localparam int          BURST = 4;
  localparam logic [28:0] BASE  = 29'h0600000;

  logic        clk;
  logic        reset;
  logic        ddram_rd;
  logic [28:0] ddram_addr;
  logic        ddram_busy;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic        flush;
  logic        mem_rd;
  logic [28:0] mem_addr;
  logic [7:0]  mem_burstcnt;
  logic        mem_waitrequest;
  logic [63:0] mem_dout;
  logic        mem_dout_ready;

  int errors = 0;
  int checks = 0;

  pgm_gfx_ddr_bridge #(
    .LINES      (LINES),
    .BURST      (BURST),
    .BASE_WADDR (BASE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ddram_rd         (ddram_rd),
    .ddram_addr       (ddram_addr),
    .ddram_busy       (ddram_busy),
    .ddram_dout       (ddram_dout),
    .ddram_dout_ready (ddram_dout_ready),
    .flush            (flush),
    .mem_rd           (mem_rd),
    .mem_addr         (mem_addr),
    .mem_burstcnt     (mem_burstcnt),
    .mem_waitrequest  (mem_waitrequest),
    .mem_dout         (mem_dout),
    .mem_dout_ready   (mem_dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // DDR memory contents: pattern 0 returns 0xA000..00 + beat number,
  // pattern 1 is a unique word per address.
  int patMode = 0;

  function automatic logic [63:0] memWord(input logic [28:0] a);
    if (patMode == 0) return 64'hA000_0000_0000_0000 + 64'(a[1:0]);
    return {3'b101, a, 3'b010, ~a};
  endfunction

  // DDR responder configuration and bookkeeping
  int          latCfg    = 3;
  int          stallCfg  = 0;
  bit          gapsOn    = 0;
  bit          strayOn   = 0;
  int          burstCount = 0;
  int          beatsGiven = 0;
  bit          burstBusy  = 0;
  logic [28:0] lastBurstAddr = '0;

  initial begin : responder
    int          delayLeft;
    int          beatIdx;
    int          stallLeft;
    int          stallSeen;
    bit          inCmd;
    logic [28:0] curAddr;
    logic [28:0] cmdAddr;
    delayLeft = 0; beatIdx = 0; stallLeft = 0; stallSeen = 0; inCmd = 0;
    curAddr = '0; cmdAddr = '0;
    mem_waitrequest = 1'b0;
    mem_dout_ready  = 1'b0;
    mem_dout        = '0;
    forever begin
      @(negedge clk);
      mem_dout_ready = 1'b0;
      mem_dout       = '0;
      if (burstBusy) begin
        if (delayLeft > 0) begin
          delayLeft--;
        end else if (!(gapsOn && $urandom_range(0, 3) == 0)) begin
          mem_dout_ready = 1'b1;
          mem_dout       = memWord(curAddr + 29'(beatIdx));
          beatIdx++;
          beatsGiven++;
          if (beatIdx == BURST) burstBusy = 0;
        end
      end else if (strayOn && $urandom_range(0, 4) == 0) begin
        mem_dout_ready = 1'b1;
        mem_dout       = {$urandom, $urandom};
      end

      mem_waitrequest = 1'b0;
      if (inCmd && !mem_rd) begin
        checkOutput("memRdHeld", 64'(mem_rd), 64'd1);
        inCmd = 0;
      end
      if (mem_rd && !reset) begin
        if (!inCmd) begin
          inCmd     = 1;
          stallLeft = stallCfg;
          stallSeen = 0;
          cmdAddr   = mem_addr;
        end else begin
          checkOutput("stallAddrStable", 64'(mem_addr), 64'(cmdAddr));
        end
        if (stallLeft > 0) begin
          mem_waitrequest = 1'b1;
          stallLeft--;
          stallSeen++;
        end else begin
          checkOutput("stallCycles", 64'(stallSeen), 64'(stallCfg));
          checkOutput("burstcnt", 64'(mem_burstcnt), 64'(BURST));
          inCmd         = 0;
          burstCount++;
          lastBurstAddr = mem_addr;
          curAddr       = mem_addr;
          burstBusy     = 1;
          delayLeft     = latCfg;
          beatIdx       = 0;
          beatsGiven    = 0;
        end
      end
    end
  end

  // Line-level cache model
  bit          refValid [LINES];
  logic [26:0] refLine  [LINES];
  logic [63:0] refData  [LINES][BURST];
  logic [63:0] lastData;

  task automatic clearModel();
    for (int i = 0; i < LINES; i++) refValid[i] = 0;
  endtask

  task automatic applyStimulus(input logic [28:0] addr, input int holdAfter,
                               input bit flushWithReq, input int flushAtBeat);
    int          idx;
    int          off;
    logic [26:0] lineNo;
    logic [28:0] expAddr;
    logic [63:0] expData;
    bit          hit;
    bit          pendFlush;
    bit          got;
    bit          flushed;
    int          k;
    int          b0;
    idx     = int'(addr[5:2]);
    off     = int'(addr[1:0]);
    lineNo  = addr[28:2];
    expAddr = BASE + {lineNo, 2'b00};
    if (flushWithReq) clearModel();
    hit = refValid[idx] && (refLine[idx] == lineNo);
    if (!hit) begin
      for (int b = 0; b < BURST; b++) refData[idx][b] = memWord(expAddr + 29'(b));
      refValid[idx] = 1;
      refLine[idx]  = lineNo;
    end
    expData   = refData[idx][off];
    pendFlush = (flushAtBeat >= 0) && !hit;
    b0        = burstCount;

    @(negedge clk);
    ddram_rd   = 1'b1;
    ddram_addr = addr;
    flush      = flushWithReq;
    k = 0; got = 0; flushed = 0;
    while (k < 300 && !got) begin
      @(negedge clk);
      k++;
      flush = 1'b0;
      if (pendFlush && !flushed && burstCount > b0 && beatsGiven > flushAtBeat) begin
        flush   = 1'b1;
        flushed = 1;
      end
      if (ddram_dout_ready) got = 1;
    end
    flush = 1'b0;
    checkOutput("respSeen", 64'(got), 64'd1);
    checkOutput("respData", ddram_dout, expData);
    lastData = ddram_dout;
    if (hit) checkOutput("hitLatency", 64'(k), 64'd2);
    checkOutput("burstsIssued", 64'(burstCount - b0), hit ? 64'd0 : 64'd1);
    if (!hit) checkOutput("burstAddr", 64'(lastBurstAddr), 64'(expAddr));

    for (int h = 0; h <= holdAfter; h++) begin
      if (h == holdAfter) ddram_rd = 1'b0;
      @(negedge clk);
      checkOutput("singlePulse", 64'(ddram_dout_ready), 64'd0);
      checkOutput("noReaccept", 64'(ddram_busy), 64'd0);
    end
    if (pendFlush) clearModel();
  endtask

  initial begin : main
    int          b0;
    int          w;
    bit          sawReady;
    bit          sawBusy;
    logic [28:0] a;
    reset      = 1'b1;
    ddram_rd   = 1'b0;
    ddram_addr = '0;
    flush      = 1'b0;
    clearModel();
    repeat (3) @(negedge clk);
    checkOutput("rstBusy",     64'(ddram_busy), 64'd0);
    checkOutput("rstReady",    64'(ddram_dout_ready), 64'd0);
    checkOutput("rstDout",     ddram_dout, 64'd0);
    checkOutput("rstMemRd",    64'(mem_rd), 64'd0);
    checkOutput("rstMemAddr",  64'(mem_addr), 64'd0);
    checkOutput("rstBurstcnt", 64'(mem_burstcnt), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed cases");
    applyStimulus(29'h000005, 0, 0, -1);
    checkOutput("coldAddr", 64'(lastBurstAddr), 64'h0600004);
    checkOutput("coldData", lastData, 64'hA000_0000_0000_0001);
    applyStimulus(29'h000006, 0, 0, -1);
    checkOutput("hitData", lastData, 64'hA000_0000_0000_0002);
    applyStimulus(29'h000045, 0, 0, -1);
    checkOutput("evictAddr", 64'(lastBurstAddr), 64'h0600044);
    applyStimulus(29'h000005, 0, 0, -1);

    stallCfg = 5;
    applyStimulus(29'h000100, 0, 0, -1);
    stallCfg = 0;
    applyStimulus(29'h000101, 3, 0, -1);

    applyStimulus(29'h000200, 0, 0, 0);
    applyStimulus(29'h000200, 0, 0, -1);
    applyStimulus(29'h000200, 0, 1, -1);
    applyStimulus(29'h1FA00001, 0, 0, -1);

    // reset while the line is being filled
    @(negedge clk);
    b0         = burstCount;
    ddram_rd   = 1'b1;
    ddram_addr = 29'h000300;
    w = 0;
    while (w < 200 && !(burstCount > b0 && beatsGiven >= 2)) begin
      @(negedge clk);
      w++;
    end
    checkOutput("abortReachedFill", 64'(w < 200), 64'd1);
    reset    = 1'b1;
    ddram_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clearModel();
    sawReady = 0;
    sawBusy  = 0;
    w = 0;
    while (w < 50 && (burstBusy || w < 4)) begin
      @(negedge clk);
      w++;
      if (ddram_dout_ready) sawReady = 1;
      if (ddram_busy) sawBusy = 1;
    end
    checkOutput("abortNoReady", 64'(sawReady), 64'd0);
    checkOutput("abortIdle", 64'(sawBusy), 64'd0);
    checkOutput("lateBeatsSent", 64'(beatsGiven), 64'(BURST));
    applyStimulus(29'h000300, 0, 0, -1);
    applyStimulus(29'h000303, 0, 0, -1);

    $display("[TB] randomized reads");
    patMode = 1;
    gapsOn  = 1;
    strayOn = 1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) a = 29'($urandom);
      else a = 29'($urandom_range(0, 191));
      latCfg   = $urandom_range(0, 5);
      stallCfg = $urandom_range(0, 3);
      applyStimulus(a, $urandom_range(0, 2),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 19) == 0) ? 0 : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
